// File: rtl/text_overlay_ctrl_if.sv
// ---------------------------------------------------------------------------
// text_overlay_ctrl_if
//   Groups the pixel-stream, control and font-ROM signals of the text
//   overlay into one bundle.
//
//   master : the surrounding system (sync generator, switches, font ROM)
//   slave  : the overlay controller
//
//   pix_x / pix_y   current pixel column / row
//   frame_tick      one-clk pulse per frame, during vertical blank
//   color_sel       one-hot colour request (lowest set bit wins)
//   blink_en        enable blinking
//   scroll_en       enable marquee scroll
//   chars           7-bit ASCII codes, slot 0 (leftmost) in [6:0]
//   rom_addr        {char_code, row} to the synchronous font ROM
//   font_word       ROM data, valid one clk after rom_addr
//   text_on         pixel lies inside the text box (registered)
//   text_rgb        pixel colour (registered)
// ---------------------------------------------------------------------------
interface text_overlay_ctrl_if #(
  parameter int N_CHARS = 4
);
  logic [9:0]           pix_x;
  logic [9:0]           pix_y;
  logic                 frame_tick;
  logic [7:0]           color_sel;
  logic                 blink_en;
  logic                 scroll_en;
  logic [7*N_CHARS-1:0] chars;
  logic [10:0]          rom_addr;
  logic [7:0]           font_word;
  logic                 text_on;
  logic [2:0]           text_rgb;

  modport master (
    output pix_x, pix_y, frame_tick, color_sel, blink_en, scroll_en, chars,
    output font_word,
    input  rom_addr, text_on, text_rgb
  );

  modport slave (
    input  pix_x, pix_y, frame_tick, color_sel, blink_en, scroll_en, chars,
    input  font_word,
    output rom_addr, text_on, text_rgb
  );
endinterface

// File: rtl/text_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// text_overlay_ctrl
//   Renders an N_CHARS string from an 8x16 font ROM into a rectangular box
//   at (X0, Y0), each font pixel scaled to 2^SCALE_LOG2 square screen pixels.
//   Adds a per-frame foreground colour register, frame-synchronous blink and
//   a circular marquee scroll. Pixel-in to colour-out latency is 2 clk; the
//   first clk covers the synchronous font ROM read.
//
//   clk    pixel clock
//   reset  asynchronous, active-low reset
//   bus    text_overlay_ctrl_if.slave (pixel stream, controls, font ROM,
//          text_on / text_rgb outputs)
// ---------------------------------------------------------------------------
module text_overlay_ctrl #(
  parameter int         N_CHARS       = 4,
  parameter int         SCALE_LOG2    = 3,
  parameter int         X0            = 192,
  parameter int         Y0            = 256,
  parameter logic [2:0] BG_RGB        = 3'b010,
  parameter int         BLINK_FRAMES  = 30,
  parameter int         SCROLL_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  text_overlay_ctrl_if.slave bus
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int W      = (N_CHARS * 8) << SCALE_LOG2;
  localparam int H      = 16 << SCALE_LOG2;
  localparam int IDX_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int SLOTS  = 1 << IDX_W;
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  // Box bounds in 11 bits so X0+W == 1024 is representable and a pixel left
  // of / above the box never wraps into it.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + H);

  localparam logic [IDX_W:0]    N_EXT     = (IDX_W + 1)'(N_CHARS);
  localparam logic [IDX_W-1:0]  OFF_LAST  = IDX_W'(N_CHARS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCROLL_FRAMES - 1);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (X0 + W > 1024 || Y0 + H > 1024) begin : g_bad_geometry
    $error("text_overlay_ctrl: text box exceeds the 1024x1024 pixel space");
  end
  if (N_CHARS < 1 || N_CHARS > 16) begin : g_bad_n_chars
    $error("text_overlay_ctrl: N_CHARS must be 1..16");
  end
  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
    $error("text_overlay_ctrl: SCALE_LOG2 must be 0..3");
  end
  if (BLINK_FRAMES < 1 || SCROLL_FRAMES < 1) begin : g_bad_frames
    $error("text_overlay_ctrl: BLINK_FRAMES and SCROLL_FRAMES must be >= 1");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              in_box_q;                 // stage 1: pixel valid / in box
  logic [2:0]        col_q;                    // stage 1: font column
  logic              text_on_q;                // stage 2
  logic [2:0]        text_rgb_q, text_rgb_d;   // stage 2
  logic [2:0]        fg_q, fg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]  offset_q, offset_d;

  // -------------------------------------------------------------------------
  // Stage 0: box test and font address (combinational)
  // -------------------------------------------------------------------------
  logic            in_box;
  logic [9:0]      dx, dy;
  logic [2:0]      col;
  logic [3:0]      row;
  logic [IDX_W-1:0] slot_idx;
  logic [IDX_W:0]  idx_sum, idx_wrap;
  logic [IDX_W-1:0] char_idx;
  logic [6:0]      char_tab [SLOTS];

  assign in_box = ({1'b0, bus.pix_x} >= X_LO) && ({1'b0, bus.pix_x} < X_HI) &&
                  ({1'b0, bus.pix_y} >= Y_LO) && ({1'b0, bus.pix_y} < Y_HI);

  // Offsets are only meaningful inside the box; outside, rom_addr is forced 0.
  assign dx       = bus.pix_x - 10'(X0);
  assign dy       = bus.pix_y - 10'(Y0);
  assign col      = dx[SCALE_LOG2 +: 3];
  assign row      = dy[SCALE_LOG2 +: 4];
  assign slot_idx = dx[SCALE_LOG2 + 3 +: IDX_W];

  // Unpack the string; slots beyond N_CHARS pad the table to a power of two
  // and are never selected because char_idx is reduced mod N_CHARS.
  for (genvar g = 0; g < SLOTS; g++) begin : g_char_tab
    if (g < N_CHARS) begin : g_used
      assign char_tab[g] = bus.chars[7*g +: 7];
    end else begin : g_pad
      assign char_tab[g] = 7'h00;
    end
  end

  // (slot + offset) mod N_CHARS: both operands are < N_CHARS, so a single
  // conditional subtract is enough.
  assign idx_sum  = {1'b0, slot_idx} + {1'b0, offset_q};
  assign idx_wrap = idx_sum - N_EXT;
  assign char_idx = (idx_sum >= N_EXT) ? idx_wrap[IDX_W-1:0] : idx_sum[IDX_W-1:0];

  assign bus.rom_addr = in_box ? {char_tab[char_idx], row} : 11'h000;

  logic unused_bits;
  assign unused_bits = ^{dx, dy, idx_wrap};

  // -------------------------------------------------------------------------
  // Stage 2 colour and frame-rate control next-state logic
  // -------------------------------------------------------------------------
  logic lit;
  logic blank;

  // font_word arrives one clk after rom_addr, so it lines up with the
  // stage-1 column rather than the live pixel column.
  assign lit   = bus.font_word[3'd7 - col_q];
  assign blank = bus.blink_en && blink_phase_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    text_rgb_d    = 3'b000;
    fg_d          = fg_q;
    bcnt_d        = bcnt_q;
    blink_phase_d = blink_phase_q;
    scnt_d        = scnt_q;
    offset_d      = offset_q;

    if (in_box_q) begin
      text_rgb_d = (lit && !blank) ? fg_q : BG_RGB;
    end

    // Colour: lowest set bit of color_sel; descending scan so the lowest
    // index is written last and wins. All zero leaves fg unchanged.
    if (bus.frame_tick) begin
      for (int i = 7; i >= 0; i--) begin
        if (bus.color_sel[i]) fg_d = 3'(i);
      end
    end

    if (!bus.blink_en) begin
      bcnt_d        = '0;
      blink_phase_d = 1'b0;
    end else if (bus.frame_tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    // With N_CHARS == 1, OFF_LAST is 0 and offset stays at 0.
    if (!bus.scroll_en) begin
      scnt_d = '0;
    end else if (bus.frame_tick) begin
      if (scnt_q == SCNT_LAST) begin
        scnt_d   = '0;
        offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_box_q      <= 1'b0;
      col_q         <= 3'd0;
      text_on_q     <= 1'b0;
      text_rgb_q    <= 3'b000;
      fg_q          <= 3'b111;
      bcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      scnt_q        <= '0;
      offset_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      in_box_q      <= in_box;
      col_q         <= col;
      text_on_q     <= in_box_q;
      text_rgb_q    <= text_rgb_d;
      fg_q          <= fg_d;
      bcnt_q        <= bcnt_d;
      blink_phase_q <= blink_phase_d;
      scnt_q        <= scnt_d;
      offset_q      <= offset_d;
    end
  end

  assign bus.text_on  = text_on_q;
  assign bus.text_rgb = text_rgb_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_overlay_ctrl
//   Self-checking bench. A font ROM with random contents sits on the bus;
//   expected addresses and colours come from a division/modulo model of the
//   text box, and blink/scroll state is derived from counted frame ticks.
//   BLINK_FRAMES=2 and SCROLL_FRAMES=3 keep frame sequences short while
//   still exercising the frame counters.
// ---------------------------------------------------------------------------
module tb_text_overlay_ctrl;

  localparam int         N   = 4;
  localparam int         SL  = 3;
  localparam int         S   = 1 << SL;
  localparam int         X0  = 192;
  localparam int         Y0  = 256;
  localparam int         W   = N * 8 * S;
  localparam int         H   = 16 * S;
  localparam logic [2:0] BG  = 3'b010;
  localparam int         BF  = 2;
  localparam int         SF  = 3;

  logic clk;
  logic reset;

  text_overlay_ctrl_if #(.N_CHARS(N)) bus ();

  text_overlay_ctrl #(
    .N_CHARS(N), .SCALE_LOG2(SL), .X0(X0), .Y0(Y0), .BG_RGB(BG),
    .BLINK_FRAMES(BF), .SCROLL_FRAMES(SF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous font ROM
  logic [7:0] font_mem [2048];
  always @(posedge clk) bus.font_word <= font_mem[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         m_fg;
  int         m_bticks;   // ticks seen since blink was enabled
  int         m_steps;    // scroll steps from earlier enabled runs
  int         m_run;      // ticks in the current enabled scroll run
  logic [6:0] m_chars [N];

  typedef struct {
    int         x;
    int         y;
    logic       on;
    logic [2:0] rgb;
  } exp_t;

  function automatic int m_offset();
    return (m_steps + m_run / SF) % N;
  endfunction

  function automatic int m_phase();
    return bus.blink_en ? (m_bticks / BF) % 2 : 0;
  endfunction

  function automatic void model_pixel(input int x, input int y,
                                      output logic [10:0] addr,
                                      output logic on, output logic [2:0] rgb);
    int slot, col, row, code;
    logic lit;
    if (x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) begin
      slot = (x - X0) / (8 * S);
      col  = ((x - X0) / S) % 8;
      row  = ((y - Y0) / S) % 16;
      code = int'(m_chars[(slot + m_offset()) % N]);
      addr = 11'(code * 16 + row);
      lit  = font_mem[addr][7 - col];
      on   = 1'b1;
      rgb  = (lit && !(bus.blink_en && m_phase() == 1)) ? 3'(m_fg) : BG;
    end else begin
      addr = 11'h000;
      on   = 1'b0;
      rgb  = 3'b000;
    end
  endfunction

  task automatic model_reset();
    m_fg = 7; m_bticks = 0; m_steps = 0; m_run = 0;
  endtask

  task automatic drive_chars();
    for (int i = 0; i < N; i++) bus.chars[7*i +: 7] = m_chars[i];
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.color_sel[i]) begin
        m_fg = i;
        break;
      end
    end
    if (bus.blink_en)  m_bticks++;
    if (bus.scroll_en) m_run++;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic set_blink(input logic v);
    @(negedge clk);
    if (!v) m_bticks = 0;
    bus.blink_en = v;
  endtask

  task automatic set_scroll(input logic v);
    @(negedge clk);
    if (!v && bus.scroll_en) begin
      m_steps += m_run / SF;
      m_run    = 0;
    end
    bus.scroll_en = v;
  endtask

  // Streams n random pixels around the box; rom_addr checked 1 ns after
  // each drive, text_on/text_rgb checked two negedges later.
  task automatic stream_pixels(input int n, input string tag);
    exp_t        q[$];
    exp_t        e;
    logic [10:0] a;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = q.pop_front();
        checks++;
        if (bus.text_on !== e.on) begin
          errors++;
          $display("FAIL %s text_on (%0d,%0d): got %b expected %b", tag, e.x, e.y, bus.text_on, e.on);
        end
        checks++;
        if (bus.text_rgb !== e.rgb) begin
          errors++;
          $display("FAIL %s text_rgb (%0d,%0d): got %b expected %b", tag, e.x, e.y, bus.text_rgb, e.rgb);
        end
      end
      if (k < n) begin
        e.x = int'($urandom_range(X0 + W + 16, X0 - 16));
        e.y = int'($urandom_range(Y0 + H + 16, Y0 - 16));
        bus.pix_x = 10'(e.x);
        bus.pix_y = 10'(e.y);
        model_pixel(e.x, e.y, a, e.on, e.rgb);
        #1;
        checks++;
        if (bus.rom_addr !== a) begin
          errors++;
          $display("FAIL %s rom_addr (%0d,%0d): got %h expected %h", tag, e.x, e.y, bus.rom_addr, a);
        end
        q.push_back(e);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    bus.pix_x = 10'd192;
    bus.pix_y = 10'd256;
    #2;
    checks++;
    if (bus.text_on !== 1'b0 || bus.text_rgb !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b expected 0/000", bus.text_on, bus.text_rgb);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.text_on !== 1'b0 || bus.text_rgb !== 3'b000) begin
      errors++;
      $display("FAIL reset_held: got %b/%b expected 0/000", bus.text_on, bus.text_rgb);
    end
    checks++;
    if (bus.rom_addr !== 11'h450) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h expected 450", bus.rom_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_geometry();
    int         tx   [5] = '{192, 256, 191, 192, 447};
    int         ty   [5] = '{256, 264, 256, 384, 383};
    logic [10:0] ta  [5] = '{11'h450, 11'h4C1, 11'h000, 11'h000, 11'h03F};
    logic       ton  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] trgb [5] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111};
    font_mem[11'h450] = 8'h80;   // column 0 lit
    font_mem[11'h4C1] = 8'h80;   // column 0 lit
    font_mem[11'h03F] = 8'h01;   // column 7 lit
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pix_x = 10'(tx[i]);
      bus.pix_y = 10'(ty[i]);
      #1;
      checks++;
      if (bus.rom_addr !== ta[i]) begin
        errors++;
        $display("FAIL geom_addr (%0d,%0d): got %h expected %h", tx[i], ty[i], bus.rom_addr, ta[i]);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.text_on !== ton[i] || bus.text_rgb !== trgb[i]) begin
        errors++;
        $display("FAIL geom_out (%0d,%0d): got %b/%b expected %b/%b",
                 tx[i], ty[i], bus.text_on, bus.text_rgb, ton[i], trgb[i]);
      end
    end
  endtask

  task automatic test_random_pixels();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) m_chars[i] = 7'($urandom);
      drive_chars();
      stream_pixels(40, "random_pixels");
    end
  endtask

  task automatic test_color();
    @(negedge clk);
    bus.color_sel = 8'b0001_0100;
    stream_pixels(30, "color_midframe");   // fg must still be white
    tick();
    stream_pixels(30, "color_green");
    @(negedge clk);
    bus.color_sel = 8'h00;
    tick();
    stream_pixels(30, "color_hold");
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      bus.color_sel = 8'($urandom);
      tick();
      stream_pixels(20, "color_random");
    end
  endtask

  task automatic test_blink();
    set_blink(1'b1);
    for (int f = 1; f <= 6; f++) begin
      tick();
      stream_pixels(24, "blink_frames");
    end
    set_blink(1'b0);
    stream_pixels(24, "blink_off");
  endtask

  task automatic test_scroll();
    logic [10:0] a;
    logic        on;
    logic [2:0]  rgb;
    for (int i = 0; i < N; i++) m_chars[i] = 7'($urandom);
    drive_chars();
    set_scroll(1'b1);
    for (int f = 0; f < 14; f++) begin
      if (f == 5) set_scroll(1'b0);
      if (f == 7) set_scroll(1'b1);
      tick();
      @(negedge clk);
      bus.pix_x = 10'd192;
      bus.pix_y = 10'd256;
      model_pixel(192, 256, a, on, rgb);
      #1;
      checks++;
      if (bus.rom_addr !== a) begin
        errors++;
        $display("FAIL scroll_slot0 tick %0d: got %h expected %h", f, bus.rom_addr, a);
      end
      stream_pixels(12, "scroll_stream");
    end
    set_scroll(1'b0);
  endtask

  task automatic test_simultaneous();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      bus.color_sel = 8'($urandom);
      set_blink(1'($urandom));
      set_scroll(1'($urandom));
      tick();
      stream_pixels(20, "simultaneous");
    end
    set_blink(1'b0);
    set_scroll(1'b0);
  endtask

  task automatic test_async_reset();
    logic [10:0] a;
    logic        on;
    logic [2:0]  rgb;
    int          guard;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_blink(1'b1);
    set_scroll(1'b1);
    guard = 0;
    while (!(m_offset() == 2 && m_phase() == 1) && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL async_setup: model state not reached, offset %0d phase %0d", m_offset(), m_phase());
    end
    stream_pixels(20, "pre_reset");
    // Hold an in-box pixel so the outputs are active before reset.
    @(negedge clk);
    bus.pix_x = 10'd200;
    bus.pix_y = 10'd260;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.text_on !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_on: got %b expected 1", bus.text_on);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.text_on !== 1'b0 || bus.text_rgb !== 3'b000) begin
      errors++;
      $display("FAIL async_outputs: got %b/%b expected 0/000", bus.text_on, bus.text_rgb);
    end
    model_pixel(200, 260, a, on, rgb);
    checks++;
    if (bus.rom_addr !== a) begin
      errors++;
      $display("FAIL async_rom_addr: got %h expected %h", bus.rom_addr, a);
    end
    @(negedge clk);
    reset = 1'b1;
    set_scroll(1'b0);
    stream_pixels(40, "post_reset");
    set_blink(1'b0);
  endtask

  initial begin
    bus.pix_x      = 10'd0;
    bus.pix_y      = 10'd0;
    bus.frame_tick = 1'b0;
    bus.color_sel  = 8'h00;
    bus.blink_en   = 1'b0;
    bus.scroll_en  = 1'b0;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    m_chars[0] = 7'h45;
    m_chars[1] = 7'h4C;
    m_chars[2] = 7'h43;
    m_chars[3] = 7'h03;
    drive_chars();
    model_reset();

    test_reset();
    test_geometry();
    test_random_pixels();
    test_color();
    test_blink();
    test_scroll();
    test_simultaneous();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Parametrised, pipelined successor to the fixed "initials" VGA text overlay.
- Renders an N-character string from the 8x16 font ROM. Position and integer power-of-two scale are set by parameters.
- Foreground colour is held in a register, updated once per frame from the one-hot colour switches.
- Adds frame-synchronous blink and a circular marquee scroll. Correctly compensates for the 1-cycle latency of the synchronous font ROM.
- Sits between the VGA sync generator and the RGB output mux.

Parameters:
- N_CHARS, 4, number of character slots (1..16).
- SCALE_LOG2, 3, each font pixel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (0..3).
- X0, 192, left edge of text box in pixels.
- Y0, 256, top edge of text box in pixels.
- BG_RGB, 3'b010, colour of unlit pixels inside the box.
- BLINK_FRAMES, 30, frames per blink half-period (>=1).
- SCROLL_FRAMES, 60, frames per one-slot scroll step (>=1).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- frame_tick  in  1  one-clk pulse, once per frame, during vertical blank.
- color_sel  in  8  one-hot colour request: bit0 Black, bit1 Blue, bit2 Green, bit3 Cyan, bit4 Red, bit5 Magenta, bit6 Yellow, bit7 White.
- blink_en  in  1  enable blinking.
- scroll_en  in  1  enable marquee scroll.
- chars  in  7*N_CHARS  ASCII codes; slot 0 (leftmost) in bits [6:0].
- rom_addr  out  11  {char_code[6:0], row[3:0]} to the synchronous font ROM.
- font_word  in  8  ROM data, valid 1 clk after rom_addr.
- text_on  out  1  pixel lies inside the text box (registered).
- text_rgb  out  3  pixel colour (registered).

Behaviour:
- Geometry:
  - W = N_CHARS*8 << SCALE_LOG2, H = 16 << SCALE_LOG2.
  - Box = X0 <= pix_x < X0+W and Y0 <= pix_y < Y0+H.
  - Compare using 11-bit arithmetic, so no wrap for pix_x < X0.
  - Elaboration error if X0+W > 1024 or Y0+H > 1024.
- Stage 0 (combinational from pix_x/pix_y):
  - dx = pix_x-X0, dy = pix_y-Y0.
  - slot = dx >> (SCALE_LOG2+3).
  - col = (dx >> SCALE_LOG2)[2:0].
  - row = (dy >> SCALE_LOG2)[3:0].
  - char = chars slot (slot+offset) mod N_CHARS.
  - rom_addr = {char,row} inside the box, 11'h000 outside.
- Stage 1 register: in_box_d, col_d.
- Stage 2 register:
  - text_on <= in_box_d.
  - lit = font_word[7-col_d].
  - text_rgb <= 3'b000 if !in_box_d; else (lit && !blank) ? fg : BG_RGB.
  - blank = blink_en && blink_phase.
- Latency: pix_x/pix_y to text_on/text_rgb = 2 clk. The integrator delays hsync/vsync/video_on by 2.
- Colour register fg:
  - Samples only on frame_tick, so there is no mid-frame tearing.
  - Lowest set bit of color_sel wins: bit0 = 000 ... bit7 = 111, i.e. the value equals the bit index.
  - color_sel == 0 on the tick: fg holds.
- Blink counter:
  - On frame_tick with blink_en=1: cnt increments. At cnt == BLINK_FRAMES-1, cnt <= 0 and blink_phase toggles.
  - blink_en=0: cnt <= 0 and blink_phase <= 0 on the next clk.
- Scroll:
  - scnt counts frame_tick while scroll_en=1. At SCROLL_FRAMES-1, scnt <= 0 and offset <= (offset == N_CHARS-1) ? 0 : offset+1.
  - scroll_en=0: scnt <= 0, offset holds.
  - N_CHARS == 1: offset fixed at 0.
- Simultaneous events: colour sample, blink wrap and scroll step on the same frame_tick all take effect together. Offset and blink_phase are used from the next clk.
- Reset (any time, asynchronous):
  - text_on=0, text_rgb=000, fg=3'b111.
  - cnt=0, blink_phase=0, scnt=0, offset=0, pipeline valids=0.
  - rom_addr is combinational and follows pix_x/pix_y with offset=0.

Test Plan:
- Defaults with chars={7'h03,7'h43,7'h4C,7'h45}, pixel (192,256) -> rom_addr=11'h450. With font_word=8'h80 on the next clk, text_on=1 and text_rgb=3'b111 two clk after the pixel.
- Pixel (256,264) -> rom_addr=11'h4C1. Pixel (191,256) and (192,384) -> rom_addr=0, text_on=0, text_rgb=000. Pixel (447,383) -> in box, rom_addr=11'h03F.
- color_sel=8'b0001_0100 mid-frame -> fg unchanged until frame_tick, then lit pixels = 3'b010. color_sel=0 on the next tick -> stays 3'b010.
- blink_en=1, BLINK_FRAMES=2 -> lit pixels show BG_RGB after frames 2-3, the fg colour after frames 4-5. Drop blink_en -> lit pixels show the fg colour from the next clk.
- scroll_en=1, SCROLL_FRAMES=1 -> after 1 tick, slot 0 addresses 7'h4C (rom_addr at (192,256)=11'h4C0). After 4 ticks, back to 7'h45 (wrap).
- Assert reset mid-line with offset=2 and blink_phase=1 -> outputs 000/0 immediately without a clk edge. After release, fg=111, offset=0, no blink.
